// File: rtl/ptp_rtc.sv
// IEEE 1588 real-time clock: 48-bit seconds + ns.frac time of day advanced
// every cycle by a programmable fixed-point period, with a counted temporary
// period offset and a 24-bit delta-sigma accumulator for the sub-fraction bits.
module ptp_rtc (
  input  logic        clk,
  input  logic        rst,
  input  logic        time_ld,
  input  logic [37:0] time_reg_ns_in,
  input  logic [47:0] time_reg_sec_in,
  input  logic        period_ld,
  input  logic [39:0] period_in,
  input  logic        adj_ld,
  input  logic [31:0] adj_ld_data,
  input  logic [39:0] period_adj,
  output logic        adj_ld_done,
  output logic [37:0] time_reg_ns,
  output logic [47:0] time_reg_sec,
  output logic [37:0] time_ptp_ns,
  output logic [47:0] time_ptp_sec
);

  localparam int unsigned NS_W   = 38;
  localparam int unsigned SEC_W  = 48;
  localparam int unsigned PER_W  = 40;
  localparam int unsigned CNT_W  = 32;
  localparam int unsigned FRAC_W = 24;
  localparam logic [NS_W-1:0] MOD_NS = 38'd256_000_000_000;

  logic [PER_W-1:0]  period;
  logic [PER_W-1:0]  adj;
  logic [CNT_W-1:0]  adj_cnt;
  logic [FRAC_W-1:0] frac_acc;
  logic [NS_W-1:0]   time_ns;
  logic [SEC_W-1:0]  time_sec;

  logic [NS_W-1:0]   time_acc_modulo;
  logic [PER_W-1:0]  time_adj_08n_32f;
  logic [CNT_W-1:0]  adj_cnt_next;
  logic [FRAC_W:0]   frac_sum;
  logic [NS_W-1:0]   step;
  logic [NS_W:0]     sum;
  logic              time_acc_48s_inc;

  assign time_reg_ns  = time_ns;
  assign time_reg_sec = time_sec;

  // Increment selection, delta-sigma carry and seconds-rollover detection
  always_comb begin
    time_acc_modulo  = MOD_NS;
    time_adj_08n_32f = period;
    adj_cnt_next     = adj_cnt;
    if (adj_cnt != '0) begin
      time_adj_08n_32f = period + adj;
      adj_cnt_next     = adj_cnt - CNT_W'(1);
    end
    if (adj_ld) begin
      adj_cnt_next = adj_ld_data;
    end
    frac_sum = {1'b0, frac_acc} + {1'b0, time_adj_08n_32f[FRAC_W-1:0]};
    step     = NS_W'(time_adj_08n_32f[PER_W-1:FRAC_W]) + NS_W'(frac_sum[FRAC_W]);
    sum      = {1'b0, time_ns} + {1'b0, step};
    time_acc_48s_inc = (sum >= {1'b0, time_acc_modulo});
  end

  // Clock state, loads and the one-cycle-delayed PTP copy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period       <= '0;
      adj          <= '0;
      adj_cnt      <= '0;
      frac_acc     <= '0;
      time_ns      <= '0;
      time_sec     <= '0;
      adj_ld_done  <= 1'b1;
      time_ptp_ns  <= '0;
      time_ptp_sec <= '0;
    end else begin
      if (period_ld) begin
        period <= period_in;
      end
      if (adj_ld) begin
        adj <= period_adj;
      end
      adj_cnt      <= adj_cnt_next;
      adj_ld_done  <= (adj_cnt_next == '0);
      frac_acc     <= frac_sum[FRAC_W-1:0];
      time_ptp_ns  <= time_ns;
      time_ptp_sec <= time_sec;
      if (time_ld) begin
        time_ns  <= time_reg_ns_in;
        time_sec <= time_reg_sec_in;
      end else if (time_acc_48s_inc) begin
        time_ns  <= NS_W'(sum - {1'b0, time_acc_modulo});
        time_sec <= time_sec + SEC_W'(1);
      end else begin
        time_ns  <= NS_W'(sum);
      end
    end
  end

endmodule

// File: tb/tb_ptp_rtc.sv
// Randomized self-checking bench for ptp_rtc against an arithmetic time model.
module tb_ptp_rtc;

  localparam longint unsigned MOD    = 64'd256000000000;
  localparam longint unsigned MASK40 = 64'hFF_FFFF_FFFF;
  localparam longint unsigned MASK48 = 64'hFFFF_FFFF_FFFF;
  localparam longint unsigned MASK24 = 64'hFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        time_ld = 1'b0;
  logic [37:0] time_reg_ns_in = '0;
  logic [47:0] time_reg_sec_in = '0;
  logic        period_ld = 1'b0;
  logic [39:0] period_in = '0;
  logic        adj_ld = 1'b0;
  logic [31:0] adj_ld_data = '0;
  logic [39:0] period_adj = '0;
  logic        adj_ld_done;
  logic [37:0] time_reg_ns;
  logic [47:0] time_reg_sec;
  logic [37:0] time_ptp_ns;
  logic [47:0] time_ptp_sec;

  int n_chk = 0;
  int n_bad = 0;

  // Reference model state (plain integers)
  longint unsigned m_period, m_adj, m_cnt, m_acc, m_ns, m_sec, m_pns, m_psec;
  logic m_done;

  ptp_rtc dut (
    .clk(clk), .rst(rst), .time_ld(time_ld), .time_reg_ns_in(time_reg_ns_in),
    .time_reg_sec_in(time_reg_sec_in), .period_ld(period_ld), .period_in(period_in),
    .adj_ld(adj_ld), .adj_ld_data(adj_ld_data), .period_adj(period_adj),
    .adj_ld_done(adj_ld_done), .time_reg_ns(time_reg_ns), .time_reg_sec(time_reg_sec),
    .time_ptp_ns(time_ptp_ns), .time_ptp_sec(time_ptp_sec)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_period = 0; m_adj = 0; m_cnt = 0; m_acc = 0;
    m_ns = 0; m_sec = 0; m_pns = 0; m_psec = 0; m_done = 1'b1;
  endtask

  // Total elapsed 2^-32 ns is split into whole ns*2^8 units; only the carry
  // out of the low 24 bits of the running total moves time forward.
  task automatic model_edge();
    longint unsigned inc, total, step, t;
    m_pns  = m_ns;
    m_psec = m_sec;
    inc = (m_cnt != 0) ? ((m_period + m_adj) & MASK40) : m_period;
    if (m_cnt != 0) m_cnt = m_cnt - 1;
    total = m_acc + inc;
    step  = total >> 24;
    m_acc = total & MASK24;
    if (time_ld) begin
      m_ns  = 64'(time_reg_ns_in);
      m_sec = 64'(time_reg_sec_in);
    end else begin
      t     = m_ns + step;
      m_sec = (m_sec + t / MOD) & MASK48;
      m_ns  = t % MOD;
    end
    if (period_ld) m_period = 64'(period_in);
    if (adj_ld) begin
      m_adj = 64'(period_adj);
      m_cnt = 64'(adj_ld_data);
    end
    m_done = (m_cnt == 0);
  endtask

  task automatic check_all();
    check("ns",   64'(time_reg_ns),  m_ns);
    check("sec",  64'(time_reg_sec), m_sec);
    check("pns",  64'(time_ptp_ns),  m_pns);
    check("psec", 64'(time_ptp_sec), m_psec);
    check("done", 64'(adj_ld_done),  64'(m_done));
  endtask

  // One clock: model advance with the driven inputs, edge, then compare
  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
    time_ld = 1'b0; period_ld = 1'b0; adj_ld = 1'b0;
  endtask

  // Asynchronous reset between edges; outputs must clear before the next edge
  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    check("rst_ns",   64'(time_reg_ns),  64'd0);
    check("rst_sec",  64'(time_reg_sec), 64'd0);
    check("rst_pns",  64'(time_ptp_ns),  64'd0);
    check("rst_psec", 64'(time_ptp_sec), 64'd0);
    check("rst_done", 64'(adj_ld_done),  64'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  longint unsigned start_ns;

  initial begin
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;

    // 8 ns period, integer only
    period_in = 40'h08_0000_0000; period_ld = 1'b1;
    cyc();
    repeat (5) cyc();
    check("lin_ns", 64'(time_reg_ns), 64'd40 * 256);

    // Seconds rollover from a time load
    time_reg_ns_in  = 38'(64'd999999990 * 256);
    time_reg_sec_in = 48'd10;
    time_ld = 1'b1;
    cyc();
    check("ld_ns", 64'(time_reg_ns), 64'd999999990 * 256);
    cyc();
    check("ld_ns2", 64'(time_reg_ns), 64'd999999998 * 256);
    cyc();
    check("wrap_ns", 64'(time_reg_ns), 64'd6 * 256);
    check("wrap_sec", 64'(time_reg_sec), 64'd11);

    // Fractional period, 256-cycle exact advance
    time_reg_ns_in = '0; time_reg_sec_in = '0; time_ld = 1'b1;
    period_in = 40'h08_1020_0000; period_ld = 1'b1;
    cyc();
    cyc();
    start_ns = 64'(time_reg_ns);
    repeat (256) cyc();
    check("frac256", 64'(time_reg_ns) - start_ns, 64'd528416);

    // Counted adjustment of 10 cycles
    period_adj = 40'h02_2080_0000; adj_ld_data = 32'd10; adj_ld = 1'b1;
    cyc();
    check("adj_lo0", 64'(adj_ld_done), 64'd0);
    repeat (9) cyc();
    check("adj_lo9", 64'(adj_ld_done), 64'd0);
    cyc();
    check("adj_hi", 64'(adj_ld_done), 64'd1);
    repeat (4) cyc();

    // Zero-count adjustment
    period_adj = '0; adj_ld_data = '0; adj_ld = 1'b1;
    cyc();
    check("adj0_done", 64'(adj_ld_done), 64'd1);
    repeat (3) cyc();

    // Reset in the middle of an adjustment
    period_adj = 40'h01_0000_0000; adj_ld_data = 32'd50; adj_ld = 1'b1;
    cyc();
    repeat (5) cyc();
    async_reset();
    repeat (3) cyc();
    check("post_rst_hold", 64'(time_reg_ns), 64'd0);

    // Random operation
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 3) begin
        period_in = {8'($urandom_range(0, 255)), 32'($urandom)};
        period_ld = 1'b1;
      end
      r = int'($urandom_range(0, 99));
      if (r < 3) begin
        period_adj  = {8'($urandom_range(0, 255)), 32'($urandom)};
        adj_ld_data = 32'($urandom_range(0, 20));
        adj_ld = 1'b1;
      end
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        if ($urandom_range(0, 1) == 1) begin
          time_reg_ns_in  = 38'(MOD - 64'($urandom_range(1, 20000)));
          time_reg_sec_in = ($urandom_range(0, 1) == 1) ? 48'hFFFF_FFFF_FFFF
                                                        : {16'($urandom), 32'($urandom)};
        end else begin
          time_reg_ns_in  = 38'({32'($urandom), 32'($urandom)} % MOD);
          time_reg_sec_in = {16'($urandom), 32'($urandom)};
        end
        time_ld = 1'b1;
      end
      if ($urandom_range(0, 499) == 0) begin
        async_reset();
      end else begin
        cyc();
      end
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
